urish_simon_game: RTL and testbench

//  Simon memory game core for a Tiny Tapeout slot: 4 buttons, 4 LEDs, piezo speaker, 2-digit 7-seg score.

---
 rtl/urish_simon_game.sv | 278 +++++++++++++++++++++++++++
 tb/tb_urish_simon_game.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/urish_simon_game.sv
`default_nettype none
// ============================================================================
// Module   : urish_simon_game
// Brief    : Simon memory game core (4 buttons, 4 LEDs, piezo, 2-digit score).
// Revision : 1.0
// ============================================================================
module urish_simon_game #(
    parameter int CLK_HZ     = 50000,
    parameter int SHOW_MS    = 300,
    parameter int GAP_MS     = 50,
    parameter int TIMEOUT_MS = 3000,
    parameter int MUX_HZ     = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int C_SHOW = (CLK_HZ * SHOW_MS) / 1000;
    localparam int C_GAP  = (CLK_HZ * GAP_MS) / 1000;
    localparam int C_TMO  = (CLK_HZ * TIMEOUT_MS) / 1000;
    localparam int C_SEC  = CLK_HZ;
    localparam int C_DEB  = (CLK_HZ * 10) / 1000;
    localparam int C_MUX  = CLK_HZ / (2 * MUX_HZ);
    localparam int C_HP0  = CLK_HZ / (2 * 196);
    localparam int C_HP1  = CLK_HZ / (2 * 262);
    localparam int C_HP2  = CLK_HZ / (2 * 330);
    localparam int C_HP3  = CLK_HZ / (2 * 784);
    localparam int C_HPF  = CLK_HZ / (2 * 100);
    localparam int TW     = $clog2(C_TMO + C_SEC + 4 * C_GAP + C_SHOW + 1);
    localparam int DW     = $clog2(C_DEB + 1);
    localparam int MW     = $clog2(C_MUX + 1);
    localparam int HW     = $clog2(C_HPF + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_PGAP, S_WAIT, S_INPUT, S_GAP, S_FAIL, S_WIN
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d;
    logic [3:0]      deb_q, deb_d, prev_q, prev_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [15:0]     lfsr_q, lfsr_d, seed_q, seed_d, seq_q, seq_d;
    logic [1:0]      col_q, col_d, key_q, key_d;
    logic [6:0]      len_q, len_d, idx_q, idx_d;
    logic [3:0]      tens_q, tens_d, units_q, units_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            after_q, after_d;
    logic [3:0]      led_q, led_d;
    logic [2:0]      tone_q, tone_d;
    logic [HW-1:0]   tcnt_q, tcnt_d;
    logic            spk_q, spk_d;
    logic            dig1_q, dig1_d, dig2_q, dig2_d;
    logic [MW-1:0]   mcnt_q, mcnt_d;

    logic [3:0]      w_press;
    logic [15:0]     w_lfsr_nx, w_seq_nx, w_seed_nx;
    logic [TW-1:0]   w_gap_end;
    logic [HW-1:0]   w_hp;
    logic            unused_ok;

    assign w_press   = deb_q & ~prev_q;
    assign w_lfsr_nx = lfsr_next(lfsr_q);
    assign w_seq_nx  = lfsr_next(seq_q);
    assign w_seed_nx = lfsr_next(seed_q);
    // The gap after a completed round is four times the normal step gap.
    assign w_gap_end = after_q ? TW'(4 * C_GAP - 1) : TW'(C_GAP - 1);
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

    always_comb begin
        w_hp = '0;
        case (tone_q)
            3'd1: w_hp = HW'(C_HP0);
            3'd2: w_hp = HW'(C_HP1);
            3'd3: w_hp = HW'(C_HP2);
            3'd4: w_hp = HW'(C_HP3);
            3'd5: w_hp = HW'(C_HPF);
            default: w_hp = '0;
        endcase
    end

    always_comb begin
        sync1_d = ui_in[3:0];
        sync2_d = sync1_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        dcnt_d  = dcnt_q;
        prev_d  = deb_q;
        // A new level must hold unchanged for the full debounce window.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            dcnt_d = '0;
        end else if (cand_q != deb_q) begin
            if (dcnt_q == DW'(C_DEB - 1)) begin
                deb_d  = cand_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        lfsr_d  = w_lfsr_nx;
        state_d = state_q;
        tmr_d   = tmr_q;
        seed_d  = seed_q;
        seq_d   = seq_q;
        col_d   = col_q;
        key_d   = key_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tens_d  = tens_q;
        units_d = units_q;
        after_d = after_q;

        case (state_q)
            S_IDLE: if (|w_press) begin
                seed_d  = lfsr_q;
                seq_d   = w_lfsr_nx;
                col_d   = w_lfsr_nx[1:0];
                len_d   = 7'd1;
                idx_d   = 7'd0;
                tens_d  = 4'd0;
                units_d = 4'd0;
                tmr_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: if (tmr_q == TW'(C_SHOW - 1)) begin
                tmr_d   = '0;
                state_d = S_PGAP;
            end else tmr_d = tmr_q + 1'b1;
            S_PGAP: if (tmr_q == TW'(C_GAP - 1)) begin
                tmr_d = '0;
                if (idx_q == len_q - 7'd1) begin
                    idx_d   = 7'd0;
                    seq_d   = w_seed_nx;
                    col_d   = w_seed_nx[1:0];
                    state_d = S_WAIT;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    seq_d   = w_seq_nx;
                    col_d   = w_seq_nx[1:0];
                    state_d = S_SHOW;
                end
            end else tmr_d = tmr_q + 1'b1;
            S_WAIT: if (|w_press) begin
                key_d   = lowest(w_press);
                tmr_d   = '0;
                state_d = S_INPUT;
            end else if (tmr_q == TW'(C_TMO - 1)) begin
                tmr_d   = '0;
                state_d = S_FAIL;
            end else tmr_d = tmr_q + 1'b1;
            S_INPUT: if (tmr_q >= TW'(C_SHOW / 2 - 1) && !deb_q[key_q]) begin
                tmr_d   = '0;
                state_d = S_GAP;
                if (key_q != col_q) begin
                    state_d = S_FAIL;
                end else if (idx_q == len_q - 7'd1) begin
                    if (units_q == 4'd9) begin
                        if (tens_q != 4'd9) begin
                            tens_d  = tens_q + 4'd1;
                            units_d = 4'd0;
                        end
                    end else units_d = units_q + 4'd1;
                    after_d = 1'b1;
                    if (len_q == 7'd99) state_d = S_WIN;
                    else len_d = len_q + 7'd1;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    seq_d   = w_seq_nx;
                    col_d   = w_seq_nx[1:0];
                    after_d = 1'b0;
                end
            end else if (tmr_q < TW'(C_SHOW / 2 - 1)) tmr_d = tmr_q + 1'b1;
            S_GAP: if (tmr_q == w_gap_end) begin
                tmr_d = '0;
                if (after_q) begin
                    idx_d   = 7'd0;
                    seq_d   = w_seed_nx;
                    col_d   = w_seed_nx[1:0];
                    state_d = S_SHOW;
                end else state_d = S_WAIT;
            end else tmr_d = tmr_q + 1'b1;
            S_FAIL, S_WIN: if (tmr_q == TW'(C_SEC - 1)) begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end else tmr_d = tmr_q + 1'b1;
            default: state_d = S_IDLE;
        endcase

        // LED and tone follow the next state so they change on the same edge.
        led_d  = 4'h0;
        tone_d = 3'd0;
        case (state_d)
            S_SHOW:  begin led_d = 4'b0001 << col_d; tone_d = {1'b0, col_d} + 3'd1; end
            S_INPUT: begin led_d = 4'b0001 << key_d; tone_d = {1'b0, key_d} + 3'd1; end
            S_FAIL:  begin led_d = 4'hF; tone_d = 3'd5; end
            S_WIN:   led_d = (tmr_d < TW'(C_SEC / 4) ||
                             (tmr_d >= TW'(C_SEC / 2) && tmr_d < TW'(3 * C_SEC / 4))) ? 4'hF : 4'h0;
            default: ;
        endcase

        tcnt_d = tcnt_q + 1'b1;
        spk_d  = spk_q;
        if (tone_d != tone_q || tone_q == 3'd0) begin
            tcnt_d = '0;
            spk_d  = 1'b0;
        end else if (tcnt_q >= w_hp - HW'(1)) begin
            tcnt_d = '0;
            spk_d  = ~spk_q;
        end

        mcnt_d = mcnt_q + 1'b1;
        dig1_d = dig1_q;
        dig2_d = dig2_q;
        if (!dig1_q && !dig2_q) begin
            dig1_d = 1'b1;
            mcnt_d = '0;
        end else if (mcnt_q == MW'(C_MUX - 1)) begin
            mcnt_d = '0;
            dig1_d = ~dig1_q;
            dig2_d = ~dig2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= '0;  sync2_q <= '0;  cand_q <= '0;  deb_q <= '0;  prev_q <= '0;
            dcnt_q  <= '0;
            lfsr_q  <= 16'hACE1;
            seed_q  <= '0;  seq_q <= '0;  col_q <= '0;  key_q <= '0;
            len_q   <= '0;  idx_q <= '0;  tens_q <= '0;  units_q <= '0;
            tmr_q   <= '0;  after_q <= 1'b0;
            led_q   <= '0;  tone_q <= '0;  tcnt_q <= '0;  spk_q <= 1'b0;
            dig1_q  <= 1'b0;  dig2_q <= 1'b0;  mcnt_q <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;  sync2_q <= sync2_d;  cand_q <= cand_d;
            deb_q   <= deb_d;    prev_q  <= prev_d;   dcnt_q <= dcnt_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;  seq_q <= seq_d;  col_q <= col_d;  key_q <= key_d;
            len_q   <= len_d;   idx_q <= idx_d;  tens_q <= tens_d;  units_q <= units_d;
            tmr_q   <= tmr_d;   after_q <= after_d;
            led_q   <= led_d;   tone_q <= tone_d;  tcnt_q <= tcnt_d;  spk_q <= spk_d;
            dig1_q  <= dig1_d;  dig2_q <= dig2_d;  mcnt_q <= mcnt_d;
        end
    end

    assign uo_out  = {1'b0, dig2_q, dig1_q, spk_q, led_q};
    assign uio_out = {1'b0, seg7(dig1_q ? tens_q : units_q) ^ {7{ui_in[4]}}};
    assign uio_oe  = 8'h7F;
endmodule
`default_nettype wire

// File: tb/tb_urish_simon_game.sv
`default_nettype none
// ============================================================================
// Module   : tb_urish_simon_game
// Brief    : Directed self-checking bench for urish_simon_game (scaled clock).
// Revision : 1.0
// ============================================================================
module tb_urish_simon_game;
    localparam int SHOW = 1200;
    localparam int GAP  = 200;
    localparam int TMO  = 12000;
    localparam int SEC  = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;
    int c0       = 0;

    always #5 clk = ~clk;

    urish_simon_game #(
        .CLK_HZ(4000), .SHOW_MS(300), .GAP_MS(50), .TIMEOUT_MS(3000), .MUX_HZ(500)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    // Speaker full period in clocks at 4 kHz: 2*floor(4000/(2f)).
    function automatic int tone_per(input int k);
        case (k)
            0: return 20;
            1: return 14;
            2: return 12;
            3: return 4;
            default: return 40;
        endcase
    endfunction

    function automatic int led_idx(input logic [3:0] l);
        for (int i = 0; i < 4; i++) if (l[i]) return i;
        return 0;
    endfunction

    task automatic press(input logic [3:0] m, input int hold);
        ui_in[3:0] = m;
        repeat (hold) @(negedge clk);
        ui_in[3:0] = 4'h0;
    endtask

    task automatic wait_until(input logic [3:0] v, input int maxc, output int n);
        n = 0;
        while (uo_out[3:0] !== v && n < maxc) begin @(negedge clk); n++; end
    endtask

    // Counts samples while the LEDs hold v and measures the speaker period.
    task automatic span(input logic [3:0] v, input int maxc, output int n, output int per);
        int   r0;
        logic ps;
        n = 0; per = -1; r0 = -1; ps = uo_out[4];
        while (uo_out[3:0] === v && n < maxc) begin
            @(negedge clk); n++;
            if (uo_out[4] && !ps) begin
                if (r0 < 0) r0 = n;
                else if (per < 0) per = n - r0;
            end
            ps = uo_out[4];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo_out got=%h exp=00", uo_out); end
        checks++; if (uio_oe !== 8'h7F) begin failures++; $display("FAIL reset_uio_oe got=%h exp=7f", uio_oe); end
        checks++; if (uio_out !== 8'h3F) begin failures++; $display("FAIL reset_seg got=%h exp=3f", uio_out); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ((uo_out[6:5] !== 2'b01 && uo_out[6:5] !== 2'b10) || uo_out[4:0] !== 5'd0 || uio_out !== 8'h3F) begin
                failures++; $display("FAIL idle_mux cyc=%0d uo_out=%h seg=%h", i, uo_out, uio_out);
            end
        end
    endtask

    task automatic test_seginv;
        int n = 0;
        while (!uo_out[5] && n < 20) begin @(negedge clk); n++; end
        checks++; if (uo_out[5] !== 1'b1) begin failures++; $display("FAIL seginv_dig1 got=%b exp=1", uo_out[5]); end
        ui_in[4] = 1'b1; #1;
        checks++; if (uio_out !== 8'h40) begin failures++; $display("FAIL seginv_on got=%h exp=40", uio_out); end
        ui_in[4] = 1'b0; #1;
        checks++; if (uio_out !== 8'h3F) begin failures++; $display("FAIL seginv_off got=%h exp=3f", uio_out); end
        @(negedge clk);
    endtask

    task automatic test_debounce;
        int n;
        press(4'b0001, 20);
        wait_until(4'hF, 200, n);
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (uo_out[3:0] !== 4'h0) begin failures++; $display("FAIL debounce_glitch led=%h exp=0", uo_out[3:0]); end
    endtask

    task automatic test_start;
        int n, per;
        fork press(4'b0001, 80); join_none
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (!$onehot(uo_out[3:0])) begin failures++; $display("FAIL start_led got=%h exp=onehot", uo_out[3:0]); end
        c0 = led_idx(uo_out[3:0]);
        span(uo_out[3:0], SHOW + 50, n, per);
        checks++; if (n !== SHOW) begin failures++; $display("FAIL show_len got=%0d exp=%0d", n, SHOW); end
        checks++; if (per !== tone_per(c0)) begin failures++; $display("FAIL show_tone got=%0d exp=%0d", per, tone_per(c0)); end
        checks++; if (uo_out[4:0] !== 5'd0) begin failures++; $display("FAIL show_dark got=%h exp=00", uo_out[4:0]); end
    endtask

    task automatic test_correct;
        int n, m, per;
        logic [3:0] lv;
        lv = 4'(1 << c0);
        repeat (GAP + 10) @(negedge clk);
        fork press(lv, 80); join_none
        wait_until(lv, 200, n);
        checks++; if (uo_out[3:0] !== lv) begin failures++; $display("FAIL input_led got=%h exp=%h", uo_out[3:0], lv); end
        span(lv, SHOW, n, per);
        checks++; if (n !== SHOW / 2) begin failures++; $display("FAIL input_len got=%0d exp=%0d", n, SHOW / 2); end
        checks++; if (per !== tone_per(c0)) begin failures++; $display("FAIL input_tone got=%0d exp=%0d", per, tone_per(c0)); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ((uo_out[5] && uio_out !== 8'h3F) || (uo_out[6] && uio_out !== 8'h06) || uo_out[6:5] == 2'b00) begin
                failures++; $display("FAIL score_01 digs=%b seg=%h", uo_out[6:5], uio_out);
            end
            @(negedge clk);
        end
        wait_until(4'h0, 10, m);
        m = 0;
        while (uo_out[3:0] === 4'h0 && m < 4 * GAP + 50) begin @(negedge clk); m++; end
        checks++; if (m + 10 !== 4 * GAP) begin failures++; $display("FAIL round_gap got=%0d exp=%0d", m + 10, 4 * GAP); end
        checks++; if (uo_out[3:0] !== lv) begin failures++; $display("FAIL replay_first got=%h exp=%h", uo_out[3:0], lv); end
        span(lv, SHOW + 50, n, per);
        checks++; if (n !== SHOW) begin failures++; $display("FAIL replay_len got=%0d exp=%0d", n, SHOW); end
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < GAP + 50) begin @(negedge clk); n++; end
        checks++; if (n !== GAP) begin failures++; $display("FAIL step_gap got=%0d exp=%0d", n, GAP); end
        checks++; if (!$onehot(uo_out[3:0])) begin failures++; $display("FAIL step2_led got=%h exp=onehot", uo_out[3:0]); end
        span(uo_out[3:0], SHOW + 50, n, per);
    endtask

    task automatic test_wrong;
        int n, per;
        logic [3:0] wv;
        wv = 4'(1 << ((c0 + 1) % 4));
        repeat (GAP + 10) @(negedge clk);
        fork press(wv, 80); join_none
        wait_until(wv, 200, n);
        checks++; if (uo_out[3:0] !== wv) begin failures++; $display("FAIL wrong_led got=%h exp=%h", uo_out[3:0], wv); end
        span(wv, SHOW, n, per);
        checks++; if (uo_out[3:0] !== 4'hF) begin failures++; $display("FAIL fail_leds got=%h exp=f", uo_out[3:0]); end
        span(4'hF, SEC + 100, n, per);
        checks++; if (n !== SEC) begin failures++; $display("FAIL fail_len got=%0d exp=%0d", n, SEC); end
        checks++; if (per !== 40) begin failures++; $display("FAIL fail_tone got=%0d exp=40", per); end
        checks++; if (uo_out[4:0] !== 5'd0) begin failures++; $display("FAIL fail_idle got=%h exp=00", uo_out[4:0]); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ((uo_out[5] && uio_out !== 8'h3F) || (uo_out[6] && uio_out !== 8'h06)) begin
                failures++; $display("FAIL score_kept digs=%b seg=%h", uo_out[6:5], uio_out);
            end
        end
    endtask

    task automatic test_lowest;
        int n, per;
        logic [3:0] lv, mask;
        fork press(4'b0001, 80); join_none
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (!$onehot(uo_out[3:0])) begin failures++; $display("FAIL start2_led got=%h exp=onehot", uo_out[3:0]); end
        c0 = led_idx(uo_out[3:0]);
        lv = 4'(1 << c0);
        span(lv, SHOW + 50, n, per);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (uio_out !== 8'h3F) begin failures++; $display("FAIL score_cleared seg=%h exp=3f", uio_out); end
        end
        repeat (GAP) @(negedge clk);
        mask = 4'hF << c0;
        fork press(mask, 80); join_none
        wait_until(lv, 200, n);
        checks++; if (uo_out[3:0] !== lv) begin failures++; $display("FAIL lowest_wins got=%h exp=%h", uo_out[3:0], lv); end
        span(lv, SHOW, n, per);
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < 4 * GAP + 50) begin @(negedge clk); n++; end
        checks++; if (n !== 4 * GAP) begin failures++; $display("FAIL lowest_accept got=%0d exp=%0d", n, 4 * GAP); end
    endtask

    task automatic test_timeout;
        int n, per;
        logic [3:0] lv;
        lv = 4'(1 << c0);
        checks++; if (uo_out[3:0] !== lv) begin failures++; $display("FAIL replay2_first got=%h exp=%h", uo_out[3:0], lv); end
        span(uo_out[3:0], SHOW + 50, n, per);
        n = 0;
        while (uo_out[3:0] === 4'h0 && n < GAP + 50) begin @(negedge clk); n++; end
        span(uo_out[3:0], SHOW + 50, n, per);
        wait_until(4'hF, TMO + GAP + 100, n);
        checks++; if (n !== TMO + GAP) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", n, TMO + GAP); end
        checks++; if (uo_out[3:0] !== 4'hF) begin failures++; $display("FAIL timeout_leds got=%h exp=f", uo_out[3:0]); end
        repeat (1000) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL async_rst_uo got=%h exp=00", uo_out); end
        checks++; if (uio_out !== 8'h3F) begin failures++; $display("FAIL async_rst_seg got=%h exp=3f", uio_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seginv();
        test_debounce();
        test_start();
        test_correct();
        test_wrong();
        test_lowest();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
